// File: rtl/easyaxi_mst_rd_arb_if.sv
// easyaxi_mst_rd_arb_if: requester-side and AXI-side AR/R signals of the read arbiter
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_USER_W
`define AXI_USER_W 1
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif
interface easyaxi_mst_rd_arb_if #(parameter int MST_NUM = 2);
  localparam int MST_W = $clog2(MST_NUM);
  localparam int MID_W = `AXI_ID_W + MST_W;
  logic [MST_NUM-1:0] s_arvalid, s_arready, s_rvalid, s_rready;
  logic [MST_NUM*`AXI_ID_W-1:0] s_arid;
  logic [MST_NUM*`AXI_ADDR_W-1:0] s_araddr;
  logic [MST_NUM*`AXI_LEN_W-1:0] s_arlen;
  logic [MST_NUM*`AXI_SIZE_W-1:0] s_arsize;
  logic [MST_NUM*`AXI_BURST_W-1:0] s_arburst;
  logic [MST_NUM*`AXI_USER_W-1:0] s_aruser;
  logic [`AXI_ID_W-1:0] s_rid;
  logic [`AXI_DATA_W-1:0] s_rdata, m_rdata;
  logic [`AXI_RESP_W-1:0] s_rresp, m_rresp;
  logic s_rlast, m_rlast;
  logic [`AXI_USER_W-1:0] s_ruser, m_ruser;
  logic m_arvalid, m_arready, m_rvalid, m_rready;
  logic [MID_W-1:0] m_arid, m_rid;
  logic [`AXI_ADDR_W-1:0] m_araddr;
  logic [`AXI_LEN_W-1:0] m_arlen;
  logic [`AXI_SIZE_W-1:0] m_arsize;
  logic [`AXI_BURST_W-1:0] m_arburst;
  logic [`AXI_USER_W-1:0] m_aruser;
  modport slave (
    input s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_aruser, s_rready,
    output s_arready, s_rvalid, s_rid, s_rdata, s_rresp, s_rlast, s_ruser,
    output m_arvalid, m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_aruser, m_rready,
    input m_arready, m_rvalid, m_rid, m_rdata, m_rresp, m_rlast, m_ruser
  );
  modport master (
    output s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_aruser, s_rready,
    input s_arready, s_rvalid, s_rid, s_rdata, s_rresp, s_rlast, s_ruser,
    input m_arvalid, m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_aruser, m_rready,
    output m_arready, m_rvalid, m_rid, m_rdata, m_rresp, m_rlast, m_ruser
  );
endinterface

// File: rtl/easyaxi_mst_rd_arb.sv
// easyaxi_mst_rd_arb: round-robin AR arbiter with ID-prefix R routing and per-port outstanding limits
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
module easyaxi_mst_rd_arb #(
  parameter int MST_NUM = 2,
  parameter int OST_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  easyaxi_mst_rd_arb_if.slave bus,
  output logic ost_busy,
  output logic ost_err
);
  localparam int MST_W = $clog2(MST_NUM);
  localparam int OCNT_W = $clog2(OST_MAX + 1);
  localparam int MID_W = `AXI_ID_W + MST_W;
  localparam int IW = `AXI_ID_W;
  typedef enum logic {IDLE, LOCK} state_e;
  state_e state_q, state_d;
  logic [MST_W-1:0] grant_q, grant_d, last_q, last_d, pick, p;
  logic [MST_NUM-1:0] elig;
  logic [OCNT_W-1:0] cnt_q [MST_NUM];
  logic [OCNT_W-1:0] cnt_d [MST_NUM];
  logic err_q, err_d, found, hs, rhs;
  assign hs = state_q == LOCK && bus.m_arready;
  assign p = bus.m_rid[MID_W-1:IW];
  assign rhs = bus.m_rvalid && bus.m_rready && bus.m_rlast;
  // Search starts just after the last winner so every port gets a turn
  always_comb begin
    found = 1'b0;
    pick = last_q;
    for (int i = 0; i < MST_NUM; i++)
      elig[i] = bus.s_arvalid[i] && cnt_q[i] != OCNT_W'(OST_MAX);
    for (int k = 1; k <= MST_NUM; k++)
      if (!found && elig[last_q + MST_W'(k)]) begin
        found = 1'b1;
        pick = last_q + MST_W'(k);
      end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    if (state_q == IDLE && found) begin
      state_d = LOCK;
      grant_d = pick;
    end
    if (hs) begin
      state_d = IDLE;
      last_d = grant_q;
    end
  end
  // A simultaneous issue and completion on one port cancel out
  always_comb begin
    err_d = err_q;
    ost_busy = 1'b0;
    for (int i = 0; i < MST_NUM; i++) begin
      cnt_d[i] = (hs && grant_q == MST_W'(i) && !(rhs && p == MST_W'(i))) ? cnt_q[i] + OCNT_W'(1) :
                 (rhs && p == MST_W'(i) && !(hs && grant_q == MST_W'(i)) && cnt_q[i] != '0) ? cnt_q[i] - OCNT_W'(1) :
                 cnt_q[i];
      err_d = err_d | (rhs && p == MST_W'(i) && !(hs && grant_q == MST_W'(i)) && cnt_q[i] == '0);
      ost_busy = ost_busy | (cnt_q[i] != '0);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= MST_W'(MST_NUM - 1);
      err_q <= 1'b0;
      for (int i = 0; i < MST_NUM; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      err_q <= err_d;
      for (int i = 0; i < MST_NUM; i++) cnt_q[i] <= cnt_d[i];
    end
  end
  assign ost_err = err_q;
  assign bus.m_arvalid = state_q == LOCK;
  assign bus.m_arid = {grant_q, bus.s_arid[grant_q*IW +: IW]};
  assign bus.m_araddr = bus.s_araddr[grant_q*`AXI_ADDR_W +: `AXI_ADDR_W];
  assign bus.m_arlen = bus.s_arlen[grant_q*`AXI_LEN_W +: `AXI_LEN_W];
  assign bus.m_arsize = bus.s_arsize[grant_q*`AXI_SIZE_W +: `AXI_SIZE_W];
  assign bus.m_arburst = bus.s_arburst[grant_q*`AXI_BURST_W +: `AXI_BURST_W];
  assign bus.m_aruser = bus.s_aruser[grant_q*`AXI_USER_W +: `AXI_USER_W];
  assign bus.s_arready = {{(MST_NUM-1){1'b0}}, hs} << grant_q;
  assign bus.s_rvalid = {{(MST_NUM-1){1'b0}}, bus.m_rvalid} << p;
  assign bus.m_rready = bus.s_rready[p];
  assign bus.s_rid = bus.m_rid[IW-1:0];
  assign bus.s_rdata = bus.m_rdata;
  assign bus.s_rresp = bus.m_rresp;
  assign bus.s_rlast = bus.m_rlast;
  assign bus.s_ruser = bus.m_ruser;
endmodule

// File: tb/tb_easyaxi_mst_rd_arb.sv
// tb_easyaxi_mst_rd_arb: directed stimulus with an AR scoreboard checked by a separate monitor
module tb_easyaxi_mst_rd_arb;
  localparam int N = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ost_busy, ost_err;
  int tests = 0;
  int fails = 0;
  typedef struct {logic [4:0] id; logic [31:0] addr; logic [7:0] len;} ar_t;
  ar_t q[$];
  always #5 clk = ~clk;
  easyaxi_mst_rd_arb_if #(.MST_NUM(N)) bus();
  easyaxi_mst_rd_arb #(.MST_NUM(N), .OST_MAX(2)) dut (
    .clk(clk), .rst(rst), .bus(bus), .ost_busy(ost_busy), .ost_err(ost_err)
  );
  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endfunction
  always @(negedge clk) begin
    ar_t e;
    if (!rst && bus.m_arvalid && bus.m_arready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL ar_unexpected: got arid %0h addr %0h expected no handshake", bus.m_arid, bus.m_araddr);
      end else begin
        e = q.pop_front();
        chk("m_arid", 64'(bus.m_arid), 64'(e.id));
        chk("m_araddr", 64'(bus.m_araddr), 64'(e.addr));
        chk("m_arlen", 64'(bus.m_arlen), 64'(e.len));
        chk("s_arready", 64'(bus.s_arready), 64'(2'b01 << e.id[4]));
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input int i, input logic [3:0] id, input logic [31:0] addr);
    bus.s_arid[i*4 +: 4] = id;
    bus.s_araddr[i*32 +: 32] = addr;
    bus.s_arlen[i*8 +: 8] = addr[11:4];
  endtask
  task automatic exp_ar(input int i, input logic [3:0] id, input logic [31:0] addr);
    ar_t e;
    e.id = {1'(i), id};
    e.addr = addr;
    e.len = addr[11:4];
    q.push_back(e);
  endtask
  task automatic r_beat(input int port, input logic last);
    bus.m_rvalid = 1'b1;
    bus.m_rid = {1'(port), 4'h5};
    bus.m_rlast = last;
    bus.s_rready = '1;
    tick();
    bus.m_rvalid = 1'b0;
    bus.m_rlast = 1'b0;
    bus.s_rready = '0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    bus.s_arvalid = '0; bus.s_arid = '0; bus.s_araddr = '0; bus.s_arlen = '0;
    bus.s_arsize = '0; bus.s_arburst = '0; bus.s_aruser = '0; bus.s_rready = '0;
    bus.m_arready = 1'b0; bus.m_rvalid = 1'b0; bus.m_rid = '0; bus.m_rdata = '0;
    bus.m_rresp = '0; bus.m_rlast = 1'b0; bus.m_ruser = '0;
    tick(); tick();
    chk("rst_arvalid", 64'(bus.m_arvalid), 0);
    chk("rst_arready", 64'(bus.s_arready), 0);
    chk("rst_busy", 64'(ost_busy), 0);
    chk("rst_err", 64'(ost_err), 0);
    rst = 1'b0;
    // single request, first cycle latency
    req(0, 4'h3, 32'h10); exp_ar(0, 4'h3, 32'h10);
    bus.m_arready = 1'b1; bus.s_arvalid = 2'b01;
    tick();
    chk("a_arvalid", 64'(bus.m_arvalid), 1);
    chk("a_arid", 64'(bus.m_arid), 64'h03);
    tick();
    bus.s_arvalid = 2'b00;
    chk("a_busy", 64'(ost_busy), 1);
    chk("a_idle", 64'(bus.m_arvalid), 0);
    r_beat(0, 1'b1);
    chk("a_busy_clr", 64'(ost_busy), 0);
    rst = 1'b1; tick(); rst = 1'b0;
    // round robin with both requesters held valid
    req(0, 4'h1, 32'h100); req(1, 4'h2, 32'h200);
    exp_ar(0, 4'h1, 32'h100); exp_ar(1, 4'h2, 32'h200);
    exp_ar(0, 4'h1, 32'h100); exp_ar(1, 4'h2, 32'h200);
    bus.s_arvalid = 2'b11;
    repeat (8) tick();
    bus.s_arvalid = 2'b00;
    chk("b_done", 64'(q.size()), 0);
    chk("b_busy", 64'(ost_busy), 1);
    r_beat(0, 1'b0);
    r_beat(0, 1'b1); r_beat(0, 1'b1); r_beat(1, 1'b1); r_beat(1, 1'b1);
    chk("b_busy_clr", 64'(ost_busy), 0);
    chk("b_err", 64'(ost_err), 0);
    // outstanding limit blocks port 0 but not port 1
    req(0, 4'h4, 32'h300); exp_ar(0, 4'h4, 32'h300); exp_ar(0, 4'h4, 32'h300);
    bus.s_arvalid = 2'b01;
    repeat (4) tick();
    req(1, 4'h6, 32'h400); exp_ar(1, 4'h6, 32'h400);
    bus.s_arvalid = 2'b11;
    tick(); tick();
    bus.s_arvalid = 2'b01;
    repeat (3) tick();
    chk("c_throttle", 64'(bus.m_arvalid), 0);
    chk("c_arready", 64'(bus.s_arready), 0);
    r_beat(0, 1'b1);
    exp_ar(0, 4'h4, 32'h300);
    tick();
    chk("c_regrant", 64'(bus.m_arvalid), 1);
    tick();
    bus.s_arvalid = 2'b00;
    chk("c_done", 64'(q.size()), 0);
    r_beat(0, 1'b1); r_beat(0, 1'b1); r_beat(1, 1'b1);
    chk("c_busy_clr", 64'(ost_busy), 0);
    chk("c_err", 64'(ost_err), 0);
    // stall in LOCK keeps the grant and payload
    bus.m_arready = 1'b0;
    req(1, 4'h7, 32'h500); bus.s_arvalid = 2'b10;
    tick();
    req(0, 4'h8, 32'h600); bus.s_arvalid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("d_arvalid", 64'(bus.m_arvalid), 1);
      chk("d_arid", 64'(bus.m_arid), 64'h17);
      chk("d_araddr", 64'(bus.m_araddr), 64'h500);
      chk("d_arready", 64'(bus.s_arready), 0);
    end
    exp_ar(1, 4'h7, 32'h500); exp_ar(0, 4'h8, 32'h600);
    bus.m_arready = 1'b1;
    tick();
    bus.s_arvalid = 2'b01;
    tick(); tick();
    bus.s_arvalid = 2'b00;
    chk("d_done", 64'(q.size()), 0);
    r_beat(1, 1'b1); r_beat(0, 1'b1);
    chk("d_busy_clr", 64'(ost_busy), 0);
    // R routing and counter bookkeeping
    req(0, 4'h9, 32'h700); req(1, 4'hA, 32'h800);
    exp_ar(1, 4'hA, 32'h800); exp_ar(0, 4'h9, 32'h700);
    bus.s_arvalid = 2'b11;
    repeat (4) tick();
    bus.s_arvalid = 2'b00;
    bus.m_rvalid = 1'b1; bus.m_rid = 5'h12; bus.m_rlast = 1'b1;
    bus.m_rdata = 32'hCAFEF00D; bus.s_rready = 2'b01;
    #1;
    chk("e_rvalid", 64'(bus.s_rvalid), 64'b10);
    chk("e_rready", 64'(bus.m_rready), 0);
    chk("e_rid", 64'(bus.s_rid), 64'h2);
    chk("e_rdata", 64'(bus.s_rdata), 64'hCAFEF00D);
    tick();
    bus.s_rready = 2'b11;
    #1;
    chk("e_rready_hi", 64'(bus.m_rready), 1);
    tick();
    bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0; bus.s_rready = 2'b00;
    chk("e_busy_p0", 64'(ost_busy), 1);
    bus.m_rvalid = 1'b1; bus.m_rid = 5'h05; bus.s_rready = 2'b10;
    #1;
    chk("e_rvalid0", 64'(bus.s_rvalid), 64'b01);
    chk("e_rready0", 64'(bus.m_rready), 0);
    r_beat(0, 1'b1);
    chk("e_busy_clr", 64'(ost_busy), 0);
    chk("e_err", 64'(ost_err), 0);
    req(1, 4'hB, 32'h900); exp_ar(1, 4'hB, 32'h900);
    bus.s_arvalid = 2'b10;
    tick(); tick();
    req(1, 4'hC, 32'hA00); exp_ar(1, 4'hC, 32'hA00);
    tick();
    bus.m_rvalid = 1'b1; bus.m_rid = 5'h15; bus.m_rlast = 1'b1; bus.s_rready = 2'b11;
    tick();
    bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0; bus.s_rready = 2'b00; bus.s_arvalid = 2'b00;
    chk("e_same_busy", 64'(ost_busy), 1);
    r_beat(1, 1'b1);
    chk("e_same_clr", 64'(ost_busy), 0);
    chk("e_same_err", 64'(ost_err), 0);
    // reset during LOCK, then underflow
    req(0, 4'hD, 32'hB00); exp_ar(0, 4'hD, 32'hB00);
    bus.s_arvalid = 2'b01;
    tick(); tick();
    bus.s_arvalid = 2'b00;
    bus.m_arready = 1'b0;
    req(1, 4'hE, 32'hC00); bus.s_arvalid = 2'b10;
    tick();
    chk("f_lock", 64'(bus.m_arvalid), 1);
    rst = 1'b1;
    tick();
    chk("f_rst_arvalid", 64'(bus.m_arvalid), 0);
    chk("f_rst_busy", 64'(ost_busy), 0);
    rst = 1'b0;
    req(0, 4'hF, 32'hD00);
    exp_ar(0, 4'hF, 32'hD00); exp_ar(1, 4'hE, 32'hC00);
    bus.s_arvalid = 2'b11; bus.m_arready = 1'b1;
    repeat (4) tick();
    bus.s_arvalid = 2'b00;
    r_beat(0, 1'b1); r_beat(1, 1'b1);
    chk("f_busy_clr", 64'(ost_busy), 0);
    chk("f_err_pre", 64'(ost_err), 0);
    r_beat(0, 1'b1);
    chk("f_err", 64'(ost_err), 1);
    chk("f_busy", 64'(ost_busy), 0);
    tick();
    chk("f_err_sticky", 64'(ost_err), 1);
    chk("q_empty", 64'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
